playfield_scanner: RTL and testbench
====================================

// Module: playfield_scanner
// PURPOSE
//  Reader side of the game-state interface: consumes the 144-bit playfield vector (index = x + 8*y,
//  8 cols x 18 rows) written by the game controller and generates its draw_finish strobe. Per frame,
//  snapshots the vector, then streams every cell in row-major order over a valid/ready handshake
//  to the display driver. Pulses draw_finish for one cycle when the last cell is accepted.
// PARAMETERS
//  GRID_W      8       playfield columns
//  GRID_H      18      playfield rows; GRID_W*GRID_H must equal the data_updated width (144)
//  FRAME_DIV   833333  clk cycles per frame tick (60 Hz at 50 MHz); must be >= GRID_W*GRID_H+4
// PORTS
//  clk           in   1    system clock, rising edge
//  rst_n         in   1    synchronous reset, active low
//  data_updated  in   144  playfield from the game controller, bit x+8*y = cell (x,y) occupied
//  cell_x        out  3    column of the presented cell
//  cell_y        out  5    row of the presented cell
//  cell_on       out  1    occupancy of the presented cell, taken from the snapshot
//  cell_valid    out  1    cell_x/cell_y/cell_on are valid
//  cell_ready    in   1    display driver accepts the cell this cycle
//  draw_finish   out  1    one-cycle pulse; frame fully delivered
//  frame_busy    out  1    high from LATCH until the DONE cycle inclusive
//  overrun       out  1    sticky; a frame tick was dropped; cleared only by reset
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, tick counter=0, snapshot=0, pending=0. All outputs 0.
//  Reset mid-scan aborts the frame. No draw_finish is issued for an aborted frame.
//  Tick generator: counter 0..FRAME_DIV-1, wraps to 0. tick=1 on the cycle the count equals FRAME_DIV-1.
//  FSM:
//   IDLE : on tick or pending -> LATCH, and pending is cleared.
//   LATCH: snapshot<=data_updated (one cycle), x=0, y=0 -> SCAN.
//   SCAN : cell_valid=1. cell_on=snapshot[x+8*y].
//          x, y and on stay stable while cell_valid&&!cell_ready.
//          On the valid&&ready edge: x++. If x==GRID_W-1, then x=0 and y++.
//          Acceptance of (GRID_W-1, GRID_H-1) -> DONE.
//   DONE : draw_finish=1, cell_valid=0 -> IDLE. If pending is set, IDLE is left on the next cycle.
//  Latency with cell_ready held high, tick at cycle t:
//   LATCH at t+1; cell 0 valid at t+2; cell 143 at t+145; draw_finish at t+146.
//  Snapshot isolation: changes to data_updated after LATCH do not affect the current frame.
//  Tick while frame_busy: pending<=1. A tick while pending is already 1 sets overrun<=1 (tick dropped).
//  A tick in the same cycle as DONE sets pending; the next frame starts at IDLE+1.
//  cell_ready while cell_valid=0 is ignored.
//  Index arithmetic: 8-bit, x + (y<<3). Index never exceeds 143. x/y never wrap past the grid.
//  draw_finish is never high for two consecutive cycles.
// STRUCTURE
//  Shared package tetris_pkg holds:
//   GRID_W, GRID_H, CELLS=144, COORD_X_W=3, COORD_Y_W=5;
//   scan_state_t {IDLE, LATCH, SCAN, DONE};
//   cell_index(x,y) function.
//  The game controller imports the same package.
//  One sub-module, frame_tick_gen (FRAME_DIV counter, sync active-low reset, 1-cycle tick output),
//  reused by any other frame-rate logic.
//  Snapshot register, x/y counters, pending/overrun flags and FSM stay in playfield_scanner.
// TESTING (bench uses FRAME_DIV=200)
//  1 Reset: drive rst_n=0 for 3 cycles mid-SCAN -> all outputs 0; no draw_finish within 199 cycles
//    after release; first tick at cycle 199.
//  2 Full stream, ready=1, data_updated bits 0,7,143 set -> 144 cells in order (0,0)..(7,17);
//    cell_on=1 only at (0,0), (7,0), (7,17); draw_finish exactly once, 146 cycles after the tick.
//  3 Backpressure: ready toggles 1,0,0,1... -> each cell is held while ready=0; no cell skipped or
//    duplicated; 144 accepts; draw_finish after the 144th accept.
//  4 Snapshot isolation: invert data_updated at LATCH+5 -> current frame shows the original pattern;
//    the next frame shows the inverted pattern.
//  5 Overrun: hold ready=0 across 3 ticks -> pending set on tick 2, overrun=1 on tick 3; after
//    release the frame completes, the next LATCH starts 1 cycle after IDLE, and overrun stays 1.
//  6 Row wrap: accept (7,0) -> next presented cell is (0,1) with index 8 = data_updated[8].

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared playfield geometry, scanner state encoding and cell indexing.
package tetris_pkg;

    localparam int GRID_W    = 8;
    localparam int GRID_H    = 18;
    localparam int CELLS     = GRID_W * GRID_H;
    localparam int COORD_X_W = 3;
    localparam int COORD_Y_W = 5;
    localparam int INDEX_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // Flat bit position of cell (x,y); rows are GRID_W = 8 wide, so y*8 is a shift.
    function automatic logic [INDEX_W-1:0] cell_index(
        input logic [COORD_X_W-1:0] x,
        input logic [COORD_Y_W-1:0] y
    );
        return INDEX_W'(x) + (INDEX_W'(y) << 3);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one-cycle tick every FRAME_DIV clocks.
module frame_tick_gen #(
    parameter int FRAME_DIV = 833333
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // Count 0..FRAME_DIV-1 and wrap; tick is decoded from the terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CNT_W'(1);
    end

    assign tick = (cnt == CNT_W'(FRAME_DIV - 1));

endmodule

// File: rtl/playfield_scanner.sv
// Snapshots the playfield once per frame and streams it cell by cell over valid/ready.
module playfield_scanner
    import tetris_pkg::*;
#(
    parameter int FRAME_DIV = 833333
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CELLS-1:0]     data_updated,
    output logic [COORD_X_W-1:0] cell_x,
    output logic [COORD_Y_W-1:0] cell_y,
    output logic                 cell_on,
    output logic                 cell_valid,
    input  logic                 cell_ready,
    output logic                 draw_finish,
    output logic                 frame_busy,
    output logic                 overrun
);

    scan_state_t          state_q, state_d;
    logic                 tick;
    logic [CELLS-1:0]     snap_q;
    logic [COORD_X_W-1:0] x_q;
    logic [COORD_Y_W-1:0] y_q;
    logic                 pending_q;
    logic                 overrun_q;
    logic                 last_cell;
    logic                 accept;

    frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign last_cell = (x_q == COORD_X_W'(GRID_W - 1)) && (y_q == COORD_Y_W'(GRID_H - 1));
    assign accept    = (state_q == SCAN) && cell_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_d     = state_q;
        cell_valid  = 1'b0;
        draw_finish = 1'b0;
        frame_busy  = 1'b0;
        cell_on     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick || pending_q) state_d = LATCH;
            end
            LATCH: begin
                frame_busy = 1'b1;
                state_d    = SCAN;
            end
            SCAN: begin
                frame_busy = 1'b1;
                cell_valid = 1'b1;
                cell_on    = snap_q[cell_index(x_q, y_q)];
                if (cell_ready && last_cell) state_d = DONE;
            end
            DONE: begin
                frame_busy  = 1'b1;
                draw_finish = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot, raster counters and the pending/overrun bookkeeping for ticks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // A tick arriving while one is already queued has nowhere to go.
            if (tick && pending_q) overrun_q <= 1'b1;

            if (state_q == IDLE) begin
                if (tick || pending_q) pending_q <= 1'b0;
            end else if (tick) begin
                pending_q <= 1'b1;
            end

            if (state_q == LATCH) begin
                snap_q <= data_updated;
                x_q    <= '0;
                y_q    <= '0;
            end else if (accept) begin
                // Park at (0,0) after the last cell so the counters never leave the grid.
                if (last_cell) begin
                    x_q <= '0;
                    y_q <= '0;
                end else if (x_q == COORD_X_W'(GRID_W - 1)) begin
                    x_q <= '0;
                    y_q <= y_q + COORD_Y_W'(1);
                end else begin
                    x_q <= x_q + COORD_X_W'(1);
                end
            end
        end
    end

    assign cell_x  = x_q;
    assign cell_y  = y_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_playfield_scanner.sv
// Bench for playfield_scanner: frame-position reference model plus directed scenarios.
module tb_playfield_scanner;

    localparam int FDIV  = 200;
    localparam int NCELL = 144;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCELL-1:0] data_updated;
    logic [2:0]       cell_x;
    logic [4:0]       cell_y;
    logic             cell_on;
    logic             cell_valid;
    logic             cell_ready;
    logic             draw_finish;
    logic             frame_busy;
    logic             overrun;

    playfield_scanner #(.FRAME_DIV(FDIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_updated (data_updated),
        .cell_x       (cell_x),
        .cell_y       (cell_y),
        .cell_on      (cell_on),
        .cell_valid   (cell_valid),
        .cell_ready   (cell_ready),
        .draw_finish  (draw_finish),
        .frame_busy   (frame_busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: a frame is a single position counter.
    // -1 idle, 0 latch, 1..144 presenting cell pos-1, 145 finish.
    int               m_tcnt = 0;
    int               m_pos  = -1;
    bit               m_pend = 0;
    bit               m_ovr  = 0;
    bit [NCELL-1:0]   m_snap = '0;

    typedef struct { int x; int y; bit on; } cell_t;
    cell_t acc[$];

    typedef struct { int n; int x; int y; bit on; } vec_t;
    vec_t tbl[6];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic logic [NCELL-1:0] rand144();
        logic [NCELL-1:0] v;
        for (int i = 0; i < NCELL; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // One clock: advance the model from the current inputs, then check after the edge.
    task automatic step();
        bit tk;
        bit ev;
        if (cell_valid && cell_ready) acc.push_back('{int'(cell_x), int'(cell_y), cell_on});
        if (!rst_n) begin
            m_tcnt = 0; m_pos = -1; m_pend = 0; m_ovr = 0; m_snap = '0;
        end else begin
            tk     = (m_tcnt == FDIV - 1);
            m_tcnt = (m_tcnt + 1) % FDIV;
            if (tk && m_pend) m_ovr = 1;
            if (m_pos < 0) begin
                if (tk || m_pend) begin m_pos = 0; m_pend = 0; end
            end else begin
                if (tk) m_pend = 1;
                if (m_pos == 0) begin m_snap = data_updated; m_pos = 1; end
                else if (m_pos <= NCELL) begin if (cell_ready) m_pos++; end
                else m_pos = -1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        ev = (m_pos >= 1 && m_pos <= NCELL);
        chk("valid",   32'(cell_valid),  32'(ev));
        chk("busy",    32'(frame_busy),  32'(m_pos >= 0));
        chk("finish",  32'(draw_finish), 32'(m_pos == NCELL + 1));
        chk("overrun", 32'(overrun),     32'(m_ovr));
        chk("on",      32'(cell_on),     ev ? 32'(m_snap[m_pos-1]) : 32'd0);
        if (ev) begin
            chk("x", 32'(cell_x), 32'((m_pos - 1) % 8));
            chk("y", 32'(cell_y), 32'((m_pos - 1) / 8));
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_busy(input int maxc, output int n);
        n = 0;
        while (!frame_busy && n < maxc) begin step(); n++; end
        chk("busy_timeout", 32'(frame_busy), 32'd1);
    endtask

    task automatic wait_finish(input int maxc, output int n);
        n = 0;
        while (!draw_finish && n < maxc) begin step(); n++; end
        chk("finish_timeout", 32'(draw_finish), 32'd1);
    endtask

    // Compare the accepted stream against the expected raster of pattern p.
    task automatic check_stream(input string nm, input logic [NCELL-1:0] p);
        int bad;
        bad = 0;
        chk({nm, "_count"}, 32'(acc.size()), 32'(NCELL));
        foreach (acc[i])
            if (acc[i].x != i % 8 || acc[i].y != i / 8 || acc[i].on != p[i]) bad++;
        chk({nm, "_order"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int n, nf, nb;
        logic [NCELL-1:0] d, p2;

        tbl[0] = '{0,   0, 0,  1'b1};
        tbl[1] = '{7,   7, 0,  1'b1};
        tbl[2] = '{8,   0, 1,  1'b0};
        tbl[3] = '{63,  7, 7,  1'b0};
        tbl[4] = '{142, 6, 17, 1'b0};
        tbl[5] = '{143, 7, 17, 1'b1};

        // Power-on reset: everything idle and zero.
        rst_n = 1'b0; cell_ready = 1'b0; data_updated = '0;
        repeat (3) step();
        chk("rst_x", 32'(cell_x), 32'd0);
        chk("rst_y", 32'(cell_y), 32'd0);
        rst_n = 1'b1;

        // Full stream, ready held high, bits 0/7/143 set.
        d = '0; d[0] = 1'b1; d[7] = 1'b1; d[143] = 1'b1;
        data_updated = d;
        cell_ready   = 1'b1;
        wait_busy(300, n);
        chk("first_latch", 32'(n), 32'd200);
        acc.delete();
        wait_finish(200, n);
        chk("finish_lat", 32'(n), 32'd145);
        check_stream("full", d);
        foreach (tbl[i])
            if (tbl[i].n < acc.size()) begin
                chk("tbl_x",  32'(acc[tbl[i].n].x),  32'(tbl[i].x));
                chk("tbl_y",  32'(acc[tbl[i].n].y),  32'(tbl[i].y));
                chk("tbl_on", 32'(acc[tbl[i].n].on), 32'(tbl[i].on));
            end
        nf = 0;
        repeat (40) begin step(); nf += int'(draw_finish); end
        chk("single_finish", 32'(nf), 32'd0);

        // Reset in the middle of a scan aborts the frame.
        wait_busy(300, n);
        repeat (20) step();
        rst_n = 1'b0;
        repeat (3) step();
        chk("mid_rst_valid",  32'(cell_valid),  32'd0);
        chk("mid_rst_busy",   32'(frame_busy),  32'd0);
        chk("mid_rst_finish", 32'(draw_finish), 32'd0);
        chk("mid_rst_xy",     32'({cell_x, cell_y, cell_on, overrun}), 32'd0);
        rst_n = 1'b1;
        nf = 0; nb = 0;
        repeat (199) begin step(); nf += int'(draw_finish); nb += int'(frame_busy); end
        chk("post_rst_finish", 32'(nf), 32'd0);
        chk("post_rst_busy",   32'(nb), 32'd0);
        step();
        chk("post_rst_latch", 32'(frame_busy), 32'd1);

        // Backpressure: ready pattern 1,0,0 repeating.
        do_reset(2);
        d = rand144();
        d[8] = 1'b1;
        data_updated = d;
        acc.delete();
        n = 0;
        for (int i = 0; i < 800; i++) begin
            cell_ready = (i % 3 == 0);
            step();
            n = i;
            if (draw_finish) break;
        end
        chk("bp_finish", 32'(draw_finish), 32'd1);
        check_stream("bp", d);
        if (acc.size() > 8) begin
            chk("wrap_x",  32'(acc[8].x),  32'd0);
            chk("wrap_y",  32'(acc[8].y),  32'd1);
            chk("wrap_on", 32'(acc[8].on), 32'd1);
        end

        // Snapshot isolation: flip the input five cycles after LATCH.
        do_reset(2);
        cell_ready = 1'b1;
        d = rand144();
        data_updated = d;
        wait_busy(300, n);
        acc.delete();
        repeat (5) step();
        p2 = ~d;
        data_updated = p2;
        wait_finish(200, n);
        check_stream("iso1", d);
        step();
        acc.delete();
        wait_busy(300, n);
        wait_finish(200, n);
        check_stream("iso2", p2);

        // Overrun: ready low across three ticks.
        do_reset(2);
        cell_ready = 1'b0;
        data_updated = rand144();
        wait_busy(300, n);
        repeat (399) step();
        chk("ovr_before", 32'(overrun), 32'd0);
        step();
        chk("ovr_set", 32'(overrun), 32'd1);
        cell_ready = 1'b1;
        wait_finish(200, n);
        step();
        chk("ovr_idle", 32'(frame_busy), 32'd0);
        step();
        chk("ovr_relatch", 32'(frame_busy), 32'd1);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Random traffic against the model.
        do_reset(2);
        for (int i = 0; i < 2500; i++) begin
            cell_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) data_updated = rand144();
            rst_n = ($urandom_range(0, 999) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
